// File: rtl/mac_tg_pkg.sv
// mac_tg_pkg -- shared definitions for the MAC accumulator block.
//   mac_state_t : controller states (IDLE / ACC / HOLD)
//   N_DEF       : default operand / product / accumulator width
//   K_DEF       : default number of products summed per result
package mac_tg_pkg;

    localparam int N_DEF = 32;
    localparam int K_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_tg_mult.sv
// mac_tg_mult -- combinational unsigned N x N -> 2N multiplier.
// Truncation or saturation of the product is left to the caller.
//   a : multiplicand (N bits)
//   b : multiplier   (N bits)
//   p : full product (2N bits)
module mac_tg_mult
    import mac_tg_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    // Zero-extend both operands so the multiply is evaluated at full width.
    assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/mac_tg_acc.sv
// mac_tg_acc -- sums K unsigned products g_input*e_input into one result.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   g_input,e_input : operand pair (N bits each)
//   in_valid        : operand pair present
//   in_ready        : block accepts a pair (low only while a result is held)
//   clr             : synchronous abort of the current block; beats
//                     and o_ready in the same cycle are ignored
//   o, o_valid      : completed result, valid one cycle after the Kth beat
//   o_ready         : consumer takes the result
//   o_sat           : sticky saturation flag for the current result
//
// Build option: MAC_TG_SAT_EN selects saturating arithmetic (clamp at
// 2^N-1, o_sat reports clamping). Without it, sums wrap modulo 2^N and
// o_sat is tied low.
module mac_tg_acc
    import mac_tg_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] g_input,
    input  logic [N-1:0] e_input,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         clr,
    output logic [N-1:0] o,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_sat
);

    localparam int CW = $clog2(K + 1);
    // cnt value seen while the Kth beat is being accepted
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);

    mac_state_t     state;
    logic [N-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic           sat_q;

    logic [2*N-1:0] prod_full;
    logic [N-1:0]   prod;
    logic [N-1:0]   sum;
    logic           prod_ovf;
    logic           sum_ovf;
    logic           beat;

    mac_tg_mult #(.N(N)) u_mult (
        .a (g_input),
        .b (e_input),
        .p (prod_full)
    );

`ifdef MAC_TG_SAT_EN
    logic [N:0] sum_w;

    // Clamp the product first, then the sum; once acc sits at 2^N-1 any
    // nonzero add overflows again and re-clamps, so it stays pinned there.
    always_comb begin
        prod_ovf = |prod_full[2*N-1:N];
        prod     = prod_ovf ? '1 : prod_full[N-1:0];
        sum_w    = {1'b0, acc} + {1'b0, prod};
        sum_ovf  = sum_w[N];
        sum      = sum_ovf ? '1 : sum_w[N-1:0];
    end

    assign o_sat = sat_q;
`else
    logic unused_bits;

    always_comb begin
        prod_ovf = 1'b0;
        prod     = prod_full[N-1:0];
        sum_ovf  = 1'b0;
        sum      = acc + prod;
    end

    assign o_sat       = 1'b0;
    assign unused_bits = ^{prod_full[2*N-1:N], sat_q};
`endif

    assign in_ready = (state != HOLD);
    assign beat     = in_valid && in_ready && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            o       <= '0;
            o_valid <= 1'b0;
            sat_q   <= 1'b0;
        end else if (clr) begin
            // o keeps its last value; only the block in flight is dropped
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        // first product of a block replaces whatever acc held
                        acc   <= prod;
                        cnt   <= CW'(1);
                        sat_q <= prod_ovf;
                        if (K == 1) begin
                            state   <= HOLD;
                            o       <= prod;
                            o_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc   <= sum;
                        cnt   <= cnt + CW'(1);
                        sat_q <= sat_q | prod_ovf | sum_ovf;
                        if (cnt == K_LAST) begin
                            state   <= HOLD;
                            o       <= sum;
                            o_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (o_ready) begin
                        state   <= IDLE;
                        acc     <= '0;
                        cnt     <= '0;
                        o_valid <= 1'b0;
                        sat_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tg_acc.sv
// tb_mac_tg_acc -- self-checking bench for mac_tg_acc (N=32, K=4) plus a
// K=1 instance. Fixed vectors from a table, hand-written corner
// sequences, then random blocks checked against a sum-of-products model.
// Expectations follow MAC_TG_SAT_EN when it is defined for the build.
module tb_mac_tg_acc;

    localparam int N  = 32;
    localparam int K  = 4;
    localparam int TW = 2*N + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] g, e;
    logic         in_valid, clr, o_ready;
    logic         in_ready, o_valid, o_sat;
    logic [N-1:0] o;

    logic [N-1:0] g1, e1;
    logic         iv1, clr1, or1;
    logic         ir1, ov1, os1;
    logic [N-1:0] o1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_tg_acc #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .g_input(g), .e_input(e),
        .in_valid(in_valid), .in_ready(in_ready), .clr(clr),
        .o(o), .o_valid(o_valid), .o_ready(o_ready), .o_sat(o_sat)
    );

    mac_tg_acc #(.N(N), .K(1)) dut1 (
        .clk(clk), .rst(rst), .g_input(g1), .e_input(e1),
        .in_valid(iv1), .in_ready(ir1), .clr(clr1),
        .o(o1), .o_valid(ov1), .o_ready(or1), .o_sat(os1)
    );

    typedef struct {
        logic [K-1:0][N-1:0] g;
        logic [K-1:0][N-1:0] e;
        logic [N-1:0]        eo;
        logic                es;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: exact sum of the full products, then wrap or clamp.
    function automatic logic [N-1:0] exp_o(input logic [TW-1:0] t);
`ifdef MAC_TG_SAT_EN
        if (|t[TW-1:N]) return '1;
`endif
        return t[N-1:0];
    endfunction

    function automatic logic exp_sat(input logic [TW-1:0] t);
`ifdef MAC_TG_SAT_EN
        return |t[TW-1:N];
`else
        return t[0] & 1'b0;
`endif
    endfunction

    task automatic beat(input logic [N-1:0] a, input logic [N-1:0] b);
        g = a; e = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Runs one K-beat block with optional random gaps and result stall.
    task automatic run_block(input logic [K-1:0][N-1:0] ga, input logic [K-1:0][N-1:0] ea,
                             input int max_gap, input logic [N-1:0] eo, input logic es,
                             input string nm);
        int hd;
        for (int i = 0; i < K; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) step();
            beat(ga[i], ea[i]);
            if (i < K-1) chk({nm, " early_o_valid"}, o_valid, 0);
        end
        chk({nm, " o_valid"}, o_valid, 1);
        chk({nm, " o"}, o, eo);
        chk({nm, " o_sat"}, o_sat, es);
        hd = (max_gap > 0) ? int'($urandom_range(3, 0)) : 0;
        repeat (hd) begin
            step();
            chk({nm, " held_o"}, o, eo);
        end
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk({nm, " released_o_valid"}, o_valid, 0);
        chk({nm, " released_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K-1:0][N-1:0] rg, re;
        logic [TW-1:0]       tot;

        vt[0].g = {32'd10, 32'd1, 32'd2, 32'd3};
        vt[0].e = {32'd10, 32'd1, 32'd7, 32'd5};
        vt[0].eo = 32'd130; vt[0].es = 1'b0;
        vt[1].g = {4{32'hFFFF_FFFF}};
        vt[1].e = {4{32'd2}};
`ifdef MAC_TG_SAT_EN
        vt[1].eo = 32'hFFFF_FFFF; vt[1].es = 1'b1;
`else
        vt[1].eo = 32'hFFFF_FFF8; vt[1].es = 1'b0;
`endif
        vt[2].g = {4{32'd1}}; vt[2].e = {4{32'd1}};
        vt[2].eo = 32'd4; vt[2].es = 1'b0;
        vt[3].g = {4{32'd0}}; vt[3].e = {4{32'hDEAD_BEEF}};
        vt[3].eo = 32'd0; vt[3].es = 1'b0;
        vt[4].g = {4{32'h0001_0000}}; vt[4].e = {4{32'h0001_0000}};
`ifdef MAC_TG_SAT_EN
        vt[4].eo = 32'hFFFF_FFFF; vt[4].es = 1'b1;
`else
        vt[4].eo = 32'd0; vt[4].es = 1'b0;
`endif
        vt[5].g = {4{32'd2}}; vt[5].e = {4{32'd3}};
        vt[5].eo = 32'd24; vt[5].es = 1'b0;

        rst = 1'b1; g = '0; e = '0; in_valid = 0; clr = 0; o_ready = 0;
        g1 = '0; e1 = '0; iv1 = 0; clr1 = 0; or1 = 0;
        #12;
        chk("reset o", o, 0);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_sat", o_sat, 0);
        chk("reset in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // table vectors
        for (int i = 0; i < 6; i++)
            run_block(vt[i].g, vt[i].e, 0, vt[i].eo, vt[i].es, $sformatf("vec%0d", i));

        // stall in HOLD with in_valid high: nothing accepted, o stable
        for (int i = 0; i < K; i++) beat(vt[0].g[i], vt[0].e[i]);
        chk("stall o_valid", o_valid, 1);
        g = 32'd1; e = 32'd1; in_valid = 1'b1; o_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall in_ready", in_ready, 0);
            chk("stall o", o, 130);
        end
        in_valid = 1'b0; o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk("stall release", o_valid, 0);
        chk("stall o retained", o, 130);
        run_block(vt[5].g, vt[5].e, 0, 32'd24, 1'b0, "after_stall");

        // clr with in_valid after 2 beats: block dropped, beat discarded
        beat(32'd9, 32'd9);
        beat(32'd9, 32'd9);
        g = 32'd5; e = 32'd5; in_valid = 1'b1; clr = 1'b1;
        step();
        in_valid = 1'b0; clr = 1'b0;
        chk("clr in_ready", in_ready, 1);
        chk("clr o_valid", o_valid, 0);
        run_block(vt[2].g, vt[2].e, 0, 32'd4, 1'b0, "after_clr");

        // asynchronous reset mid-block
        beat(32'd7, 32'd7);
        beat(32'd7, 32'd7);
        #3 rst = 1'b1;
        #1;
        chk("async_rst o", o, 0);
        chk("async_rst o_valid", o_valid, 0);
        chk("async_rst in_ready", in_ready, 1);
        #1 rst = 1'b0;
        step();
        run_block(vt[5].g, vt[5].e, 0, 32'd24, 1'b0, "after_rst");

        // K=1 instance
        for (int b = 0; b < 2; b++) begin
            g1 = 32'd7; e1 = 32'd6; iv1 = 1'b1;
            step();
            chk("k1 o", o1, 42);
            chk("k1 o_valid", ov1, 1);
            chk("k1 in_ready", ir1, 0);
            step();
            chk("k1 held in_ready", ir1, 0);
            chk("k1 held o", o1, 42);
            iv1 = 1'b0; or1 = 1'b1;
            step();
            or1 = 1'b0;
            chk("k1 release o_valid", ov1, 0);
            chk("k1 release in_ready", ir1, 1);
        end

        // random blocks against the model
        for (int n = 0; n < 25; n++) begin
            tot = '0;
            for (int i = 0; i < K; i++) begin
                if (n % 3 == 0) begin
                    rg[i] = $urandom; re[i] = $urandom;
                end else begin
                    rg[i] = $urandom_range(1000, 0); re[i] = $urandom_range(1000, 0);
                end
                tot = tot + TW'(rg[i]) * TW'(re[i]);
            end
            run_block(rg, re, 2, exp_o(tot), exp_sat(tot), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_tg_acc.md
MAC_TG_ACC -- requirements
Module: mac_tg_acc

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand, product and accumulator width in bits (N >= 2).
REQ-002 SHALL have parameter K, default 8, meaning number of products summed per result (K >= 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port g_input, input, N, multiplicand (garbler operand).
REQ-006 SHALL have port e_input, input, N, multiplier (evaluator operand).
REQ-007 SHALL have port in_valid, input, 1, operand pair present.
REQ-008 SHALL have port in_ready, output, 1, block accepts an operand pair.
REQ-009 SHALL have port clr, input, 1, synchronous abort of the current block.
REQ-010 SHALL have port o, output, N, accumulated result.
REQ-011 SHALL have port o_valid, output, 1, o holds a completed result.
REQ-012 SHALL have port o_ready, input, 1, consumer takes the result.
REQ-013 SHALL have port o_sat, output, 1, sticky saturation flag for the current result.

Function
REQ-014 SHALL define a beat as a cycle with in_valid && in_ready && !clr.
REQ-015 SHALL compute the product as unsigned g_input*e_input, with the result taken modulo 2^N when MAC_TG_SAT_EN is undefined.
REQ-016 SHALL implement states IDLE, ACC and HOLD, with in_ready = 1 in IDLE and ACC and 0 in HOLD.
REQ-017 SHALL, on a beat in IDLE, load acc with the product (no prior sum), set cnt to 1, and go to ACC, or to HOLD when K == 1.
REQ-018 SHALL, on a beat in ACC, compute acc = acc + product (mod 2^N) and increment cnt, going to HOLD on the Kth beat.
REQ-019 SHALL, on entry to HOLD, register o = final sum and o_valid = 1 one cycle after the Kth beat, so that latency is 1 cycle.
REQ-020 SHALL, in HOLD, keep o and o_sat stable until o_ready = 1, then return to IDLE with o_valid = 0 on the next cycle; o retains its last value afterwards.
REQ-021 SHALL, on clr in any state, go to IDLE with acc = 0, cnt = 0, o_valid = 0 and o_sat = 0; clr SHALL win over a simultaneous in_valid (beat discarded) and over o_ready.
REQ-022 SHALL size cnt to $clog2(K+1) bits, and cnt SHALL never exceed K.
REQ-023 SHALL hold state unchanged in ACC with in_valid = 0 (gaps allowed between beats).

Reset
REQ-024 SHALL, while rst = 1, force state = IDLE, acc = 0, cnt = 0, o = 0, o_valid = 0 and o_sat = 0 immediately, regardless of clk.
REQ-025 SHALL, on rst asserted mid-ACC or mid-HOLD, discard the partial or held result, and the first beat after release SHALL start a fresh block.

Configuration
REQ-026 SHALL use macro MAC_TG_SAT_EN; when it is defined, the full 2N-bit product and an N+1-bit sum are formed, any value >= 2^N SHALL clamp to 2^N-1, o_sat SHALL set and stay set until the block ends, and further adds to a saturated acc SHALL stay at 2^N-1.
REQ-027 SHALL, without MAC_TG_SAT_EN, use wrap-around arithmetic modulo 2^N, keep the o_sat port present, and tie o_sat to 0.

Structure
REQ-028 SHALL place the state enum (IDLE/ACC/HOLD) and the default N/K constants in shared package mac_tg_pkg.
REQ-029 SHALL implement the product in sub-module mac_tg_mult, a combinational N x N -> 2N unsigned multiplier; truncation or saturation SHALL be done in mac_tg_acc.

Verification (N=32, K=4 unless stated)
REQ-030 SHALL test that beats (3,5),(2,7),(1,1),(10,10) give o = 130 and o_valid = 1 exactly one cycle after the 4th beat.
REQ-031 SHALL test that 4 beats of (0xFFFFFFFF,2) give o = 0xFFFFFFF8 and o_sat = 0 without MAC_TG_SAT_EN, and o = 0xFFFFFFFF and o_sat = 1 with it.
REQ-032 SHALL test that with o_ready held 0 for 5 cycles in HOLD and in_valid = 1, in_ready = 0, o stays stable, and no beat is counted.
REQ-033 SHALL test that clr together with in_valid after 2 beats leads to IDLE, and that the next 4 beats of (1,1) give o = 4.
REQ-034 SHALL test that rst asserted asynchronously after 2 beats sets o = 0 and o_valid = 0 at once, and that the next block of 4 beats of (2,3) gives o = 24.
REQ-035 SHALL test that in a K=1 build each beat (7,6) gives o = 42 one cycle later, with in_ready = 0 until o_ready.
